// File: rtl/secuenciador_mac.sv
// Sequencer that feeds an external multiply-accumulate unit one product term per cycle
// and collects the M-term dot product of the coefficient set and the sample delay line.
module secuenciador_mac #(
    parameter int N = 25,
    parameter int M = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [N-1:0]     x_in,
    input  logic [N*M-1:0]   coef_in,
    output logic [N-1:0]     Constantes_G,
    output logic [N-1:0]     Multip_G,
    output logic [N-1:0]     Entrada_G,
    input  logic [N-1:0]     Valores,
    output logic [N-1:0]     y_out,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [N-1:0]     acc_reg;
    logic [N-1:0]     y_reg;
    logic [N-1:0]     c_reg     [M];
    logic [N-1:0]     x_reg     [M];
    logic [N-1:0]     coef_word [M];
    logic [N-1:0]     x_shift   [M];

    logic load, flush, mac_step, finish;

    // Unpack the coefficient bus and form the shifted view of the delay line.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_lane
            assign coef_word[gi] = coef_in[N*gi +: N];
            if (gi == 0) begin : g_head
                assign x_shift[gi] = x_in;
            end else begin : g_tail
                assign x_shift[gi] = x_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        load         = 1'b0;
        flush        = 1'b0;
        mac_step     = 1'b0;
        finish       = 1'b0;
        Constantes_G = '0;
        Multip_G     = '0;
        Entrada_G    = '0;
        case (state_reg)
            IDLE: begin
                // A flush request takes priority and swallows a simultaneous start.
                if (clr) begin
                    flush = 1'b1;
                end else if (start) begin
                    load       = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                Constantes_G = c_reg[idx_reg];
                Multip_G     = x_reg[idx_reg];
                Entrada_G    = acc_reg;
                mac_step     = 1'b1;
                if (idx_reg == IDX_LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= '0;
            acc_reg <= '0;
            y_reg   <= '0;
            for (int k = 0; k < M; k++) begin
                c_reg[k] <= '0;
                x_reg[k] <= '0;
            end
        end else begin
            if (flush) begin
                for (int k = 0; k < M; k++) begin
                    x_reg[k] <= '0;
                end
            end else if (load) begin
                for (int k = 0; k < M; k++) begin
                    x_reg[k] <= x_shift[k];
                end
            end

            if (load) begin
                for (int k = 0; k < M; k++) begin
                    c_reg[k] <= coef_word[k];
                end
                acc_reg <= '0;
                idx_reg <= '0;
            end else if (mac_step) begin
                // The external unit owns all arithmetic; its result is stored untouched.
                acc_reg <= Valores;
                if (finish) begin
                    y_reg <= Valores;
                end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                end
            end
        end
    end

    assign y_out = y_reg;
    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_secuenciador_mac.sv
// Directed and randomized checks of secuenciador_mac against a dot-product reference
// model, with the arithmetic unit modelled as Entrada_G + Constantes_G*Multip_G.
module tb_secuenciador_mac;

    localparam int N = 25;
    localparam int M = 3;
    localparam logic [63:0] MASK = (64'd1 << N) - 64'd1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           clr = 1'b0;
    logic [N-1:0]   x_in = '0;
    logic [N*M-1:0] coef_in = '0;
    logic [N-1:0]   Constantes_G, Multip_G, Entrada_G, Valores, y_out;
    logic           busy, done;

    secuenciador_mac #(.N(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
        .x_in(x_in), .coef_in(coef_in),
        .Constantes_G(Constantes_G), .Multip_G(Multip_G), .Entrada_G(Entrada_G),
        .Valores(Valores), .y_out(y_out), .busy(busy), .done(done)
    );

    assign Valores = Entrada_G + Constantes_G * Multip_G;

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: the sample history (newest first) and the last result.
    logic [N-1:0] hist [M];
    logic [N-1:0] y_model;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*M-1:0] mk_coef(input int a, input int b, input int c);
        logic [N*M-1:0] v;
        v = '0;
        v[0 +: N]   = N'(a);
        v[N +: N]   = N'(b);
        v[2*N +: N] = N'(c);
        return v;
    endfunction

    function automatic logic [N*M-1:0] rand_coef();
        logic [N*M-1:0] v;
        v = '0;
        for (int k = 0; k < M; k++) v[N*k +: N] = N'($urandom);
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < M; k++) hist[k] = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_opc"}, Constantes_G, 0);
        check({tag, "_opm"}, Multip_G, 0);
        check({tag, "_ope"}, Entrada_G, 0);
        check({tag, "_y"}, y_out, y_model);
    endtask

    // One computation starting from a negedge in IDLE; optional noise pulses start/clr
    // and scrambles coef_in/x_in while the block is busy.
    task automatic run(input logic [N-1:0] x, input logic [N*M-1:0] cf, input bit noise);
        logic [63:0]  acc;
        logic [N-1:0] cc [M];
        x_in = x;
        coef_in = cf;
        start = 1'b1;
        for (int k = M - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        for (int k = 0; k < M; k++) cc[k] = cf[N*k +: N];
        @(negedge clk);
        start = 1'b0;
        acc = 64'd0;
        for (int j = 0; j < M; j++) begin
            check("mac_busy", busy, 1);
            check("mac_done", done, 0);
            check("op_coef", Constantes_G, cc[j]);
            check("op_samp", Multip_G, hist[j]);
            check("op_acc", Entrada_G, acc);
            acc = (acc + 64'(cc[j]) * 64'(hist[j])) & MASK;
            if (noise) begin
                if (j == 1) begin
                    start = 1'b1;
                    clr = 1'b1;
                    x_in = N'($urandom);
                    coef_in = rand_coef();
                end else begin
                    start = 1'b0;
                    clr = 1'b0;
                end
            end
            @(negedge clk);
        end
        y_model = acc[N-1:0];
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_y", y_out, y_model);
        check("done_opc", Constantes_G, 0);
        check("done_ope", Entrada_G, 0);
        if (noise) begin
            start = 1'b1;
            clr = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        clr = 1'b0;
        check_quiet("after");
        $display("run x=%0h coef=%0h noise=%0d -> y=%0h (model %0h)", x, cf, noise, y_out, y_model);
    endtask

    task automatic do_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        model_clear();
        y_model = '0;
        check_quiet(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        y_model = '0;

        // Reset from power-up.
        #2;
        do_reset_check("rst0");
        check_quiet("post_rst");

        // Single run on a cleared line.
        run(N'(5), mk_coef(1, 2, 3), 1'b0);
        check("single_y", y_out, 5);

        // Three successive runs from a cleared line.
        clr = 1'b1;
        model_clear();
        @(negedge clk);
        clr = 1'b0;
        run(N'(1), mk_coef(1, 2, 3), 1'b0);
        check("three_y1", y_out, 1);
        run(N'(2), mk_coef(1, 2, 3), 1'b0);
        check("three_y2", y_out, 4);
        run(N'(3), mk_coef(1, 2, 3), 1'b0);
        check("three_y3", y_out, 10);

        // Start, clr and coef changes while busy are ignored.
        run(N'(4), mk_coef(1, 2, 3), 1'b1);
        check("busy_y", y_out, 16);
        run(N'(0), mk_coef(1, 2, 3), 1'b0);
        check("busy_shift_once", y_out, 17);

        // clr together with start in IDLE: line zeroed, start dropped.
        clr = 1'b1;
        start = 1'b1;
        x_in = N'(9);
        model_clear();
        @(negedge clk);
        clr = 1'b0;
        start = 1'b0;
        for (int i = 0; i < M + 2; i++) begin
            check_quiet("clr_start");
            @(negedge clk);
        end
        run(N'(4), mk_coef(1, 2, 3), 1'b0);
        check("clr_y", y_out, 4);

        // Reset in the middle of a computation.
        x_in = N'(11);
        coef_in = mk_coef(1, 2, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        do_reset_check("rst_mid");
        for (int i = 0; i < M + 2; i++) begin
            check_quiet("rst_idle");
            @(negedge clk);
        end
        run(N'(7), mk_coef(1, int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000))), 1'b0);
        check("rst_next_y", y_out, 7);

        // Randomized runs with occasional flushes.
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                clr = 1'b1;
                start = 1'($urandom_range(0, 1));
                model_clear();
                @(negedge clk);
                clr = 1'b0;
                start = 1'b0;
                check_quiet("rand_clr");
            end
            run(N'($urandom), rand_coef(), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
